// File: rtl/mem_stream_scheduler.sv
// Purpose : sequences frame playback from streamer memory. It issues (addr, len)
//           requests to the memory-to-AXIS engine and detects each frame's end by
//           tapping the engine's output stream.
// Latency : req_valid rises 1 cycle after entering ISSUE and 2 cycles after a tlast
//           beat (gap=0), or N+2 cycles after it (gap=N). done pulses on the cycle
//           after the final tlast beat.
// Backpressure: the request is held stable until req_ready; stream beats only
//           count when mon_tvalid & mon_tready.
// Ports   : clk, rst (sync, active-high); start/stop pulses; cfg_addr/len/step/
//           repeat/gap (latched at start); req_valid/ready/addr/len request channel;
//           mon_tvalid/tready/tlast stream tap; busy, done, error, frame_count status.
// Option  : define MEM_STREAM_SCHED_WDT_EN to enable the WAIT_FRAME watchdog.
module mem_stream_scheduler #(
  parameter  int C_MEM_SIZE    = 4,
  parameter  int C_COUNT_WIDTH = 16,
  parameter  int C_WDT_CYCLES  = 1024,
  localparam int AW = (C_MEM_SIZE > 1) ? $clog2(C_MEM_SIZE) : 1,
  localparam int LW = $clog2(C_MEM_SIZE + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [LW-1:0]            cfg_len,
  input  logic [AW-1:0]            cfg_step,
  input  logic [C_COUNT_WIDTH-1:0] cfg_repeat,
  input  logic [C_COUNT_WIDTH-1:0] cfg_gap,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [AW-1:0]            req_addr,
  output logic [LW-1:0]            req_len,
  input  logic                     mon_tvalid,
  input  logic                     mon_tready,
  input  logic                     mon_tlast,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [C_COUNT_WIDTH-1:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_FRAME,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [AW:0] MEM_SIZE_X = (AW+1)'(C_MEM_SIZE);

  state_t                   state;
  logic [AW-1:0]            step_q;
  logic [C_COUNT_WIDTH-1:0] repeat_q;
  logic [C_COUNT_WIDTH-1:0] gap_q;
  logic [C_COUNT_WIDTH-1:0] gap_cnt;
  logic                     stop_pend;

  logic                     beat;
  logic                     frame_end;
  logic [AW:0]              addr_sum;
  logic [AW:0]              addr_wrap;
  logic [AW-1:0]            addr_next;
  logic [C_COUNT_WIDTH-1:0] fc_next;
  logic                     repeat_hit;

  assign beat      = mon_tvalid & mon_tready;
  assign frame_end = beat & mon_tlast;

  // Address advance is done one bit wider so the modulo wrap also works for
  // memory depths that are not a power of two.
  always_comb begin
    addr_sum  = {1'b0, req_addr} + {1'b0, step_q};
    addr_wrap = (addr_sum >= MEM_SIZE_X) ? (addr_sum - MEM_SIZE_X) : addr_sum;
    addr_next = addr_wrap[AW-1:0];
  end

  // Saturating frame counter; repeat_q == 0 means run until stopped.
  assign fc_next    = (frame_count == {C_COUNT_WIDTH{1'b1}}) ? frame_count
                                                             : frame_count + 1'b1;
  assign repeat_hit = (repeat_q != '0) && (fc_next == repeat_q);

`ifdef MEM_STREAM_SCHED_WDT_EN
  localparam int WW = $clog2(C_WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(C_WDT_CYCLES - 1);
  logic [WW-1:0] wdt_cnt;
  logic          error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_valid   <= 1'b0;
      req_addr    <= '0;
      req_len     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
      step_q      <= '0;
      repeat_q    <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      stop_pend   <= 1'b0;
`ifdef MEM_STREAM_SCHED_WDT_EN
      wdt_cnt     <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // start beats a simultaneous stop: stop is simply not looked at here.
          if (start) begin
            req_addr    <= cfg_addr;
            req_len     <= cfg_len;
            step_q      <= cfg_step;
            repeat_q    <= cfg_repeat;
            gap_q       <= cfg_gap;
            frame_count <= '0;
            stop_pend   <= 1'b0;
            busy        <= 1'b1;
`ifdef MEM_STREAM_SCHED_WDT_EN
            error_q     <= 1'b0;
`endif
            if (cfg_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          // An accepted request wins over a same-cycle stop, which is then
          // deferred to the end of the frame.
          if (req_valid && req_ready) begin
            req_valid <= 1'b0;
            stop_pend <= stop_pend | stop;
            state     <= S_WAIT_FRAME;
`ifdef MEM_STREAM_SCHED_WDT_EN
            wdt_cnt   <= '0;
`endif
          end else if (stop) begin
            req_valid <= 1'b0;
            state     <= S_DONE;
            done      <= 1'b1;
          end else begin
            req_valid <= 1'b1;
          end
        end

        S_WAIT_FRAME: begin
          if (stop) stop_pend <= 1'b1;
          if (frame_end) begin
            frame_count <= fc_next;
            req_addr    <= addr_next;
            if (repeat_hit || stop_pend || stop) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (gap_q == '0) begin
              state <= S_ISSUE;
            end else begin
              gap_cnt <= gap_q;
              state   <= S_GAP;
            end
          end
`ifdef MEM_STREAM_SCHED_WDT_EN
          else if (beat) begin
            wdt_cnt <= '0;
          end else if (wdt_cnt == WDT_LAST) begin
            // Engine stalled: abandon the run without counting the frame.
            error_q <= 1'b1;
            state   <= S_DONE;
            done    <= 1'b1;
          end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
          end
`endif
        end

        S_GAP: begin
          if (stop) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (gap_cnt <= 1) begin
            state <= S_ISSUE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
